divisor_secuencial: RTL and testbench

DIVISOR_SECUENCIAL -- requirements
Module: divisor_secuencial

---
 rtl/divisor_secuencial.sv | 151 +++++++++++++++
 tb/tb_divisor_secuencial.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_secuencial.sv
// Sequential restoring divider: one quotient bit per cycle over N cycles, plus one DONE cycle.
// Optional macro DIVISOR_CON_SIGNO_EN selects two's-complement operands (magnitude divide + sign fix).
module divisor_secuencial #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inicio,
    input  logic [N-1:0] dividendo,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] cociente,
    output logic [N-1:0] residuo,
    output logic         ocupado,
    output logic         listo,
    output logic         div_cero
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_INI = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } estado_t;

    estado_t       estado_q;
    logic [N-1:0]  rem_q;
    logic [N-1:0]  dvd_q;
    logic [N-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;

    logic [N:0]    parcial;
    logic [N-1:0]  resta;
    logic          prestamo;
    logic          qbit;
    logic [N-1:0]  rem_d;
    logic [N-1:0]  dvd_d;
    logic [N-1:0]  carga_dvd;
    logic [N-1:0]  carga_dvs;
    logic [N-1:0]  fin_coc;
    logic [N-1:0]  fin_res;

    // Shared N+1-bit ripple-borrow subtractor: {rem, next dividend bit} - {0, divisor}.
    always_comb begin
        parcial  = {rem_q, dvd_q[N-1]};
        resta    = '0;
        prestamo = 1'b0;
        for (int i = 0; i < N; i++) begin
            resta[i] = parcial[i] ^ dvs_q[i] ^ prestamo;
            prestamo = (~parcial[i] & dvs_q[i]) | (~(parcial[i] ^ dvs_q[i]) & prestamo);
        end
        prestamo = ~parcial[N] & prestamo;
        if (!prestamo) begin
            rem_d = resta;
            qbit  = 1'b1;
        end else begin
            rem_d = parcial[N-1:0];
            qbit  = 1'b0;
        end
        dvd_d = {dvd_q[N-2:0], qbit};
    end

`ifdef DIVISOR_CON_SIGNO_EN
    logic neg_coc_q;
    logic neg_res_q;

    always_comb begin
        carga_dvd = dividendo[N-1] ? (~dividendo + 1'b1) : dividendo;
        carga_dvs = divisor[N-1]   ? (~divisor + 1'b1)   : divisor;
        fin_coc   = neg_coc_q ? (~dvd_d + 1'b1) : dvd_d;
        fin_res   = neg_res_q ? (~rem_d + 1'b1) : rem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_coc_q <= 1'b0;
            neg_res_q <= 1'b0;
        end else if (estado_q == IDLE && inicio) begin
            neg_coc_q <= dividendo[N-1] ^ divisor[N-1];
            neg_res_q <= dividendo[N-1];
        end
    end
`else
    always_comb begin
        carga_dvd = dividendo;
        carga_dvs = divisor;
        fin_coc   = dvd_d;
        fin_res   = rem_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= IDLE;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            cociente <= '0;
            residuo  <= '0;
            ocupado  <= 1'b0;
            listo    <= 1'b0;
            div_cero <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (estado_q)
                IDLE: begin
                    if (inicio) begin
                        ocupado <= 1'b1;
                        if (divisor == '0) begin
                            estado_q <= DONE;
                            cociente <= '1;
                            residuo  <= dividendo;
                            div_cero <= 1'b1;
                        end else begin
                            estado_q <= CALC;
                            dvd_q    <= carga_dvd;
                            dvs_q    <= carga_dvs;
                            rem_q    <= '0;
                            cnt_q    <= CNT_INI;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    // Counter parks at zero on the last iteration rather than wrapping.
                    if (cnt_q == '0) begin
                        estado_q <= DONE;
                        cociente <= fin_coc;
                        residuo  <= fin_res;
                        div_cero <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    estado_q <= IDLE;
                    ocupado  <= 1'b0;
                    listo    <= 1'b1;
                end
                default: begin
                    estado_q <= IDLE;
                    ocupado  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed self-checking bench for divisor_secuencial (N=32); signed cases under DIVISOR_CON_SIGNO_EN.
module tb_divisor_secuencial;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic         inicio;
    logic [N-1:0] dividendo;
    logic [N-1:0] divisor;
    logic [N-1:0] cociente;
    logic [N-1:0] residuo;
    logic         ocupado;
    logic         listo;
    logic         div_cero;

    int checks;
    int errors;

    divisor_secuencial #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .inicio    (inicio),
        .dividendo (dividendo),
        .divisor   (divisor),
        .cociente  (cociente),
        .residuo   (residuo),
        .ocupado   (ocupado),
        .listo     (listo),
        .div_cero  (div_cero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Starts one division and waits for listo; lat counts edges after the accepting edge.
    task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b,
                          output int lat, output logic busy1);
        @(negedge clk);
        dividendo = a;
        divisor   = b;
        inicio    = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        busy1  = ocupado;
        lat    = 0;
        while (listo !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (cociente !== '0) begin errors++; $display("FAIL reset_cociente got %h expected 0", cociente); end
        if (residuo !== '0) begin errors++; $display("FAIL reset_residuo got %h expected 0", residuo); end
        if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado got %b expected 0", ocupado); end
        if (listo !== 1'b0) begin errors++; $display("FAIL reset_listo got %b expected 0", listo); end
        if (div_cero !== 1'b0) begin errors++; $display("FAIL reset_div_cero got %b expected 0", div_cero); end
        rst = 1'b0;
    endtask

    task automatic test_unsigned_basic();
        int lat;
        logic b1;
        do_div(32'd100, 32'd7, lat, b1);
        checks += 6;
        if (b1 !== 1'b1) begin errors++; $display("FAIL basic_ocupado got %b expected 1", b1); end
        if (lat != 33) begin errors++; $display("FAIL basic_latency got %0d expected 33", lat); end
        if (cociente !== 32'd14) begin errors++; $display("FAIL basic_cociente got %0d expected 14", cociente); end
        if (residuo !== 32'd2) begin errors++; $display("FAIL basic_residuo got %0d expected 2", residuo); end
        if (div_cero !== 1'b0) begin errors++; $display("FAIL basic_div_cero got %b expected 0", div_cero); end
        @(negedge clk);
        if (listo !== 1'b0) begin errors++; $display("FAIL basic_listo_pulse got %b expected 0", listo); end
    endtask

    task automatic test_div_zero();
        int lat;
        logic b1;
        do_div(32'h1234, 32'd0, lat, b1);
        checks += 5;
        if (lat != 1) begin errors++; $display("FAIL dz_latency got %0d expected 1", lat); end
        if (cociente !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_cociente got %h expected ffffffff", cociente); end
        if (residuo !== 32'h1234) begin errors++; $display("FAIL dz_residuo got %h expected 1234", residuo); end
        if (div_cero !== 1'b1) begin errors++; $display("FAIL dz_div_cero got %b expected 1", div_cero); end
        if (ocupado !== 1'b0) begin errors++; $display("FAIL dz_ocupado_after got %b expected 0", ocupado); end
    endtask

    task automatic test_busy_reject();
        int first;
        int pulses;
        @(negedge clk);
        dividendo = 32'd50;
        divisor   = 32'd5;
        inicio    = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        first  = -1;
        pulses = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 5) begin
                inicio    = 1'b1;
                dividendo = 32'd9;
                divisor   = 32'd3;
            end
            if (c == 7) inicio = 1'b0;
            if (listo === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        checks += 5;
        if (first != 33) begin errors++; $display("FAIL busy_latency got %0d expected 33", first); end
        if (pulses != 1) begin errors++; $display("FAIL busy_pulses got %0d expected 1", pulses); end
        if (cociente !== 32'd10) begin errors++; $display("FAIL busy_cociente got %0d expected 10", cociente); end
        if (residuo !== 32'd0) begin errors++; $display("FAIL busy_residuo got %0d expected 0", residuo); end
        if (ocupado !== 1'b0) begin errors++; $display("FAIL busy_ocupado_end got %b expected 0", ocupado); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        int lat;
        logic b1;
        @(negedge clk);
        dividendo = 32'hFFFF_FFFF;
        divisor   = 32'd3;
        inicio    = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 5;
        if (cociente !== '0) begin errors++; $display("FAIL mid_cociente got %h expected 0", cociente); end
        if (residuo !== '0) begin errors++; $display("FAIL mid_residuo got %h expected 0", residuo); end
        if (ocupado !== 1'b0) begin errors++; $display("FAIL mid_ocupado got %b expected 0", ocupado); end
        if (listo !== 1'b0) begin errors++; $display("FAIL mid_listo got %b expected 0", listo); end
        if (div_cero !== 1'b0) begin errors++; $display("FAIL mid_div_cero got %b expected 0", div_cero); end
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (listo === 1'b1 || ocupado === 1'b1) pulses++;
        end
        checks += 1;
        if (pulses != 0) begin errors++; $display("FAIL mid_no_listo got %0d active cycles expected 0", pulses); end
        do_div(32'd8, 32'd2, lat, b1);
        checks += 3;
        if (lat != 33) begin errors++; $display("FAIL mid_next_latency got %0d expected 33", lat); end
        if (cociente !== 32'd4) begin errors++; $display("FAIL mid_next_cociente got %0d expected 4", cociente); end
        if (residuo !== 32'd0) begin errors++; $display("FAIL mid_next_residuo got %0d expected 0", residuo); end
    endtask

    task automatic test_boundary();
        int lat;
        logic b1;
        do_div(32'hFFFF_FFFF, 32'd1, lat, b1);
        checks += 3;
        if (cociente !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bnd_max_cociente got %h expected ffffffff", cociente); end
        if (residuo !== 32'd0) begin errors++; $display("FAIL bnd_max_residuo got %h expected 0", residuo); end
        if (lat != 33) begin errors++; $display("FAIL bnd_max_latency got %0d expected 33", lat); end
        do_div(32'd5, 32'd9, lat, b1);
        checks += 2;
        if (cociente !== 32'd0) begin errors++; $display("FAIL bnd_small_cociente got %0d expected 0", cociente); end
        if (residuo !== 32'd5) begin errors++; $display("FAIL bnd_small_residuo got %0d expected 5", residuo); end
    endtask

    task automatic test_back_to_back();
        int c;
        int first;
        int second;
        logic [N-1:0] q1;
        logic [N-1:0] r1;
        @(negedge clk);
        dividendo = 32'd20;
        divisor   = 32'd6;
        inicio    = 1'b1;
        c      = -1;
        first  = -1;
        second = -1;
        q1     = '0;
        r1     = '0;
        while (second < 0 && c < 150) begin
            @(negedge clk);
            c++;
            if (listo === 1'b1) begin
                if (first < 0) begin
                    first     = c;
                    q1        = cociente;
                    r1        = residuo;
                    dividendo = 32'd21;
                    divisor   = 32'd4;
                end else begin
                    second = c;
                end
            end
        end
        inicio = 1'b0;
        checks += 6;
        if (first != 33) begin errors++; $display("FAIL b2b_first_latency got %0d expected 33", first); end
        if (q1 !== 32'd3) begin errors++; $display("FAIL b2b_first_cociente got %0d expected 3", q1); end
        if (r1 !== 32'd2) begin errors++; $display("FAIL b2b_first_residuo got %0d expected 2", r1); end
        if (second != 67) begin errors++; $display("FAIL b2b_second_latency got %0d expected 67", second); end
        if (cociente !== 32'd5) begin errors++; $display("FAIL b2b_second_cociente got %0d expected 5", cociente); end
        if (residuo !== 32'd1) begin errors++; $display("FAIL b2b_second_residuo got %0d expected 1", residuo); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_sign_mode();
        int lat;
        logic b1;
`ifdef DIVISOR_CON_SIGNO_EN
        do_div(32'hFFFF_FFF9, 32'd2, lat, b1);
        checks += 3;
        if (lat != 33) begin errors++; $display("FAIL sgn_latency got %0d expected 33", lat); end
        if (cociente !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sgn_cociente got %h expected fffffffd", cociente); end
        if (residuo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sgn_residuo got %h expected ffffffff", residuo); end
        do_div(32'h8000_0000, 32'hFFFF_FFFF, lat, b1);
        checks += 2;
        if (cociente !== 32'h8000_0000) begin errors++; $display("FAIL sgn_minneg_cociente got %h expected 80000000", cociente); end
        if (residuo !== 32'd0) begin errors++; $display("FAIL sgn_minneg_residuo got %h expected 0", residuo); end
`else
        do_div(32'hFFFF_FFF9, 32'd2, lat, b1);
        checks += 2;
        if (cociente !== 32'h7FFF_FFFC) begin errors++; $display("FAIL uns_big_cociente got %h expected 7ffffffc", cociente); end
        if (residuo !== 32'd1) begin errors++; $display("FAIL uns_big_residuo got %h expected 1", residuo); end
`endif
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        inicio    = 1'b0;
        dividendo = '0;
        divisor   = '0;
        test_reset();
        test_unsigned_basic();
        test_div_zero();
        test_busy_reject();
        test_reset_mid();
        test_boundary();
        test_back_to_back();
        test_sign_mode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
